// File: rtl/rr_grant_sched8.sv
// rr_grant_sched8: round-robin scheduler sharing one resource among 8 requesters.
// Registered index/one-hot grant, revoked on done, request drop or hold timeout.
module rr_grant_sched8 #(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic       gnt_valid,
   output logic [2:0] gnt_idx,
   output logic [7:0] gnt_onehot,
   output logic       timeout
);
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

   state_t           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [2:0]       gnt_idx_q, gnt_idx_d;
   logic [7:0]       gnt_onehot_q, gnt_onehot_d;
   logic             timeout_q, timeout_d;

   logic [15:0] req_dbl;
   logic [7:0]  req_rot;
   logic [2:0]  win_ofs;
   logic [2:0]  winner;
   logic        exit_done;
   logic        exit_tmo;

   // Rotate requests so bit 0 is the current priority holder, then take the lowest set bit.
   always_comb begin
      req_dbl = {req, req};
      req_rot = req_dbl[ptr_q +: 8];
      win_ofs = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (req_rot[k]) win_ofs = 3'(k);
      end
      winner = ptr_q + win_ofs;
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      hold_cnt_d   = hold_cnt_q;
      gnt_valid_d  = gnt_valid_q;
      gnt_idx_d    = gnt_idx_q;
      gnt_onehot_d = gnt_onehot_q;
      timeout_d    = 1'b0;
      exit_done    = done | ~req[gnt_idx_q];
      exit_tmo     = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
      case (state_q)
         IDLE: begin
            if (req != 8'h00) begin
               state_d      = GRANT;
               gnt_valid_d  = 1'b1;
               gnt_idx_d    = winner;
               gnt_onehot_d = 8'h01 << winner;
               hold_cnt_d   = '0;
            end
         end
         GRANT: begin
            if (exit_done || exit_tmo) begin
               state_d      = GAP;
               gnt_valid_d  = 1'b0;
               gnt_idx_d    = 3'd0;
               gnt_onehot_d = 8'h00;
               ptr_d        = gnt_idx_q + 3'd1;
               // A voluntary release in the same cycle as expiry is not a revocation.
               timeout_d    = exit_tmo & ~exit_done;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= 3'd0;
         hold_cnt_q   <= '0;
         gnt_valid_q  <= 1'b0;
         gnt_idx_q    <= 3'd0;
         gnt_onehot_q <= 8'h00;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         hold_cnt_q   <= hold_cnt_d;
         gnt_valid_q  <= gnt_valid_d;
         gnt_idx_q    <= gnt_idx_d;
         gnt_onehot_q <= gnt_onehot_d;
         timeout_q    <= timeout_d;
      end
   end

   assign gnt_valid  = gnt_valid_q;
   assign gnt_idx    = gnt_idx_q;
   assign gnt_onehot = gnt_onehot_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_grant_sched8.sv
// Bench for rr_grant_sched8: cycle-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rr_grant_sched8;
   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic       gnt_valid;
   logic [2:0] gnt_idx;
   logic [7:0] gnt_onehot;
   logic       timeout;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   rr_grant_sched8 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .done       (done),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: phase 0 idle, 1 granted, 2 turnaround; m_held counts cycles the grant has been visible.
   int m_phase = 0;
   int m_ptr   = 0;
   int m_owner = 0;
   int m_held  = 0;
   bit m_tmo   = 1'b0;

   function automatic int first_from(logic [7:0] r, int p);
      int w;
      w = -1;
      for (int k = 7; k >= 0; k--) begin
         if (r[(p + k) % 8]) w = (p + k) % 8;
      end
      return w;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase <= 0; m_ptr <= 0; m_owner <= 0; m_held <= 0; m_tmo <= 1'b0;
      end else if (m_phase == 0) begin
         m_tmo <= 1'b0;
         if (req != 8'h00) begin
            m_owner <= first_from(req, m_ptr);
            m_phase <= 1;
            m_held  <= 1;
         end
      end else if (m_phase == 1) begin
         if (done || !req[m_owner] || (HOLD != 0 && m_held == HOLD)) begin
            m_tmo   <= !done && req[m_owner];
            m_ptr   <= (m_owner + 1) % 8;
            m_phase <= 2;
         end else begin
            m_held <= m_held + 1;
         end
      end else begin
         m_tmo   <= 1'b0;
         m_phase <= 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Compare DUT against the model on the falling edge, then advance to just past the next rising edge.
   task automatic tick();
      logic       e_valid;
      logic [2:0] e_idx;
      logic [7:0] e_oh;
      @(negedge clk);
      if (chk_en) begin
         e_valid = (m_phase == 1);
         e_idx   = e_valid ? 3'(m_owner) : 3'd0;
         e_oh    = e_valid ? (8'h01 << m_owner) : 8'h00;
         chk("model_valid", 32'(gnt_valid), 32'(e_valid));
         chk("model_idx", 32'(gnt_idx), 32'(e_idx));
         chk("model_onehot", 32'(gnt_onehot), 32'(e_oh));
         chk("model_timeout", 32'(timeout), 32'(m_tmo));
         chk("onehot0", 32'($onehot0(gnt_onehot)), 32'd1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      while (!gnt_valid && n < 12) begin
         tick();
         n++;
      end
      chk(name, 32'(gnt_valid), 32'd1);
   endtask

   task automatic finish_grant();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   int last_cyc;
   int n_hold;

   initial begin
      // T1 reset with all requests active
      rst_n = 1'b0; req = 8'hFF; done = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      chk("t1_valid", 32'(gnt_valid), 32'd0);
      chk("t1_idx", 32'(gnt_idx), 32'd0);
      chk("t1_onehot", 32'(gnt_onehot), 32'd0);
      chk("t1_timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1; req = 8'h00;
      tick();

      // T2 single requester, done, turnaround, re-grant
      req = 8'h01;
      tick();
      chk("t2_valid", 32'(gnt_valid), 32'd1);
      chk("t2_idx", 32'(gnt_idx), 32'd0);
      chk("t2_onehot", 32'(gnt_onehot), 32'h01);
      finish_grant();
      chk("t2_released", 32'(gnt_valid), 32'd0);
      chk("t2_no_tmo", 32'(timeout), 32'd0);
      tick();
      chk("t2_gap_to_idle", 32'(gnt_valid), 32'd0);
      tick();
      chk("t2_regrant", 32'(gnt_valid), 32'd1);
      chk("t2_regrant_idx", 32'(gnt_idx), 32'd0);
      finish_grant();
      req = 8'h00;
      tick(); tick();

      // T3 fairness over all lines, starting from a fresh pointer
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req = 8'hFF;
      last_cyc = 0;
      for (int g = 0; g < 9; g++) begin
         wait_grant("t3_wait");
         chk("t3_idx", 32'(gnt_idx), 32'(g % 8));
         if (g > 0) chk("t3_spacing", 32'(cyc - last_cyc), 32'd3);
         last_cyc = cyc;
         finish_grant();
      end

      // T4 pointer wrap from 7 to 0
      req = 8'h40;
      wait_grant("t4_wait6");
      chk("t4_idx6", 32'(gnt_idx), 32'd6);
      finish_grant();
      req = 8'h41;
      wait_grant("t4_wait0");
      chk("t4_idx0", 32'(gnt_idx), 32'd0);
      finish_grant();
      wait_grant("t4_wait6b");
      chk("t4_idx6b", 32'(gnt_idx), 32'd6);
      finish_grant();
      req = 8'h00;

      // T5 hold timeout, then done on the last allowed cycle
      req = 8'h08;
      wait_grant("t5_wait");
      chk("t5_idx", 32'(gnt_idx), 32'd3);
      n_hold = 1;
      tick();
      while (gnt_valid && n_hold < 10) begin
         n_hold++;
         tick();
      end
      chk("t5_hold_cycles", 32'(n_hold), 32'd4);
      chk("t5_tmo_pulse", 32'(timeout), 32'd1);
      tick();
      chk("t5_tmo_clear", 32'(timeout), 32'd0);
      tick();
      chk("t5_regrant", 32'(gnt_valid), 32'd1);
      chk("t5_regrant_idx", 32'(gnt_idx), 32'd3);
      tick(); tick(); tick();
      chk("t5_fourth_cycle", 32'(gnt_valid), 32'd1);
      finish_grant();
      chk("t5_done_release", 32'(gnt_valid), 32'd0);
      chk("t5_done_no_tmo", 32'(timeout), 32'd0);
      req = 8'h00;
      tick();

      // T6 request drop, then reset mid-grant
      req = 8'h04;
      wait_grant("t6_wait");
      chk("t6_idx", 32'(gnt_idx), 32'd2);
      tick();
      req = 8'h00;
      tick();
      chk("t6_drop_release", 32'(gnt_valid), 32'd0);
      chk("t6_drop_no_tmo", 32'(timeout), 32'd0);
      req = 8'h04;
      wait_grant("t6_wait2");
      rst_n = 1'b0;
      tick();
      chk("t6_rst_valid", 32'(gnt_valid), 32'd0);
      chk("t6_rst_idx", 32'(gnt_idx), 32'd0);
      chk("t6_rst_onehot", 32'(gnt_onehot), 32'd0);
      rst_n = 1'b1;
      req = 8'h84;
      tick();
      chk("t6_ptr_reset_idx", 32'(gnt_idx), 32'd2);
      finish_grant();
      req = 8'h00;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
